// File: rtl/beat_packer_m.sv
// Packs a stream of IN_W-bit words into registered IN_W*RATIO-bit beats with a
// per-word keep mask and a last flag, sustaining one word per clock.
module beat_packer_m #(
  parameter int IN_W  = 32,
  parameter int RATIO = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_src,
  output logic                  ready_src,
  input  logic [IN_W-1:0]       src_data,
  input  logic                  src_last,
  output logic                  valid_dst,
  input  logic                  ready_dst,
  output logic [IN_W*RATIO-1:0] dst_data,
  output logic [RATIO-1:0]      dst_keep,
  output logic                  dst_last
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int IDX_W = $clog2(RATIO);

  logic [OUT_W-1:0] acc;
  logic [RATIO-1:0] acc_keep;
  logic [IDX_W-1:0] idx;

  logic             accept;
  logic             completing;
  logic [OUT_W-1:0] data_merged;
  logic [RATIO-1:0] keep_merged;

  // Ready depends only on the output register and the sink, never on valid_src.
  assign ready_src  = !valid_dst || ready_dst;
  assign accept     = valid_src && ready_src;
  assign completing = (idx == IDX_W'(RATIO - 1)) || src_last;

  // NOTE: every always_comb output gets a full default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    data_merged                    = acc;
    keep_merged                    = acc_keep;
    data_merged[idx*IN_W +: IN_W]  = src_data;
    keep_merged[idx]               = 1'b1;
  end

  // Accumulator: words above idx are always zero, so a short beat is
  // zero-padded and its keep mask stays contiguous from bit 0.
  // NOTE: the accumulator is ordinary flop state (not a RAM), so it is reset;
  // a partial beat must never survive reset into the next packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      acc_keep <= '0;
      idx      <= '0;
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples pre-edge values regardless of statement order.
      if (completing) begin
        acc      <= '0;
        acc_keep <= '0;
        idx      <= '0;
      end else begin
        acc      <= data_merged;
        acc_keep <= keep_merged;
        idx      <= idx + 1'b1;
      end
    end
  end

  // Output register: a completing word always loads a new beat, which also
  // covers the same-edge drain-and-refill case at full throughput.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_dst <= 1'b0;
      dst_data  <= '0;
      dst_keep  <= '0;
      dst_last  <= 1'b0;
    end else if (accept && completing) begin
      valid_dst <= 1'b1;
      dst_data  <= data_merged;
      dst_keep  <= keep_merged;
      dst_last  <= src_last;
    end else if (ready_dst) begin
      valid_dst <= 1'b0;
    end
  end

endmodule

// File: tb/tb_beat_packer_m.sv
// Self-checking bench for beat_packer_m: directed cases plus a randomized run
// scored against a word-list packing model.
module tb_beat_packer_m;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_src, src_last, ready_dst;
  logic [7:0]  src_data;
  logic        ready_src, valid_dst, dst_last;
  logic [31:0] dst_data;
  logic [3:0]  dst_keep;

  logic        v2, l2, rd2, rs2, vd2, dl2;
  logic [15:0] d2;
  logic [31:0] dd2;
  logic [1:0]  dk2;

  int total = 0;
  int bad   = 0;

  beat_packer_m #(.IN_W(8), .RATIO(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .valid_src(valid_src), .ready_src(ready_src),
    .src_data(src_data), .src_last(src_last),
    .valid_dst(valid_dst), .ready_dst(ready_dst),
    .dst_data(dst_data), .dst_keep(dst_keep), .dst_last(dst_last)
  );

  beat_packer_m #(.IN_W(16), .RATIO(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .valid_src(v2), .ready_src(rs2),
    .src_data(d2), .src_last(l2),
    .valid_dst(vd2), .ready_dst(rd2),
    .dst_data(dd2), .dst_keep(dk2), .dst_last(dl2)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: accepted words collect into a list; a beat is emitted
  // when the list reaches four words or the word carries last.
  logic [7:0] cur_q[$];
  beat_t      exp_q[$];

  task automatic model_push(input logic [7:0] d, input logic l);
    beat_t b;
    cur_q.push_back(d);
    if (l || cur_q.size() == 4) begin
      b.data = '0;
      for (int i = 0; i < cur_q.size(); i++) b.data = b.data | (32'(cur_q[i]) << (8 * i));
      b.keep = 4'((1 << cur_q.size()) - 1);
      b.last = l;
      exp_q.push_back(b);
      cur_q.delete();
    end
  endtask

  logic        stalled = 1'b0;
  beat_t       held;
  beat_t       seen;
  int          n_beats = 0;
  int          cyc     = 0;

  // One clock: drive inputs on the falling edge, then observe what the next
  // rising edge will transfer.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l,
                       input logic r, output logic took);
    beat_t e;
    @(negedge clk);
    valid_src = v; src_data = d; src_last = l; ready_dst = r;
    #1;
    cyc++;
    if (stalled) begin
      check("hold_valid", valid_dst, 1'b1);
      check("hold_beat", {dst_data, dst_keep, dst_last}, held);
    end
    check("ready_rule", ready_src, !valid_dst || r);
    if (valid_dst && r) begin
      n_beats++;
      seen = '{dst_data, dst_keep, dst_last};
      if (exp_q.size() == 0) check("spurious_beat", 1'b1, 1'b0);
      else begin
        e = exp_q.pop_front();
        check("beat_data", dst_data, e.data);
        check("beat_keep", dst_keep, e.keep);
        check("beat_last", dst_last, e.last);
      end
    end
    stalled = valid_dst && !r;
    held    = '{dst_data, dst_keep, dst_last};
    took    = v && ready_src;
    if (took) model_push(d, l);
  endtask

  task automatic send_word(input logic [7:0] d, input logic l, input logic r);
    logic took;
    int   n = 0;
    do begin
      cycle(1'b1, d, l, r, took);
      n++;
    end while (!took && n < 200);
    if (!took) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle(input logic r);
    logic took;
    cycle(1'b0, 8'($urandom), 1'($urandom), r, took);
  endtask

  initial begin
    logic took;
    int   c0, b0;

    rst_n = 1'b0;
    valid_src = 1'b0; src_data = '0; src_last = 1'b0; ready_dst = 1'b0;
    v2 = 1'b0; d2 = '0; l2 = 1'b0; rd2 = 1'b1;
    @(negedge clk); #1;
    check("rst_out", {valid_dst, dst_last, dst_keep, dst_data}, 64'd0);
    check("rst_out2", {vd2, dl2, dk2, dd2}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two back-to-back full beats, no stall
    c0 = cyc; b0 = n_beats;
    for (int i = 1; i <= 5; i++) send_word(8'(i), 1'b0, 1'b1);
    check("t1_beat1", seen, {32'h04030201, 4'hF, 1'b0});
    for (int i = 6; i <= 8; i++) send_word(8'(i), i == 8, 1'b1);
    check("t1_cycles", cyc - c0, 8);
    idle(1'b1);
    check("t1_beat2", seen, {32'h08070605, 4'hF, 1'b1});
    check("t1_nbeats", n_beats - b0, 2);
    idle(1'b1);
    check("t1_idle_valid", valid_dst, 1'b0);

    // Short beats
    send_word(8'hAA, 1'b0, 1'b1);
    send_word(8'hBB, 1'b1, 1'b1);
    idle(1'b1);
    check("t2_short2", seen, {32'h0000BBAA, 4'h3, 1'b1});
    send_word(8'hCC, 1'b1, 1'b1);
    idle(1'b1);
    check("t2_short1", seen, {32'h000000CC, 4'h1, 1'b1});

    // Backpressure
    for (int i = 1; i <= 4; i++) send_word(8'(8'h30 + i), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 8'h55, 1'b0, 1'b0, took);
      check("t3_stall_take", took, 1'b0);
      check("t3_stall_data", {valid_dst, dst_data}, {1'b1, 32'h34333231});
    end
    cycle(1'b1, 8'h55, 1'b0, 1'b1, took);
    check("t3_release_take", took, 1'b1);
    check("t3_release_beat", seen, {32'h34333231, 4'hF, 1'b0});
    for (int i = 6; i <= 8; i++) send_word(8'(8'h50 + i), i == 8, 1'b1);
    idle(1'b1);
    check("t3_resume", seen, {32'h58575655, 4'hF, 1'b1});

    // Asynchronous reset mid-beat
    for (int i = 1; i <= 6; i++) send_word(8'(8'h20 + i), 1'b0, 1'b1);
    check("t4_pre_data", dst_data, 32'h24232221);
    @(negedge clk); #2;
    rst_n = 1'b0;
    valid_src = 1'b0;
    #1;
    check("t4_async_out", {valid_dst, dst_last, dst_keep, dst_data}, 64'd0);
    cur_q.delete(); exp_q.delete(); stalled = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) send_word(8'(8'h10 + i), 1'b0, 1'b1);
    idle(1'b1);
    check("t4_after_rst", seen, {32'h14131211, 4'hF, 1'b0});

    // RATIO=2, IN_W=16 instance
    @(negedge clk); v2 = 1'b1; d2 = 16'h1234; l2 = 1'b0; #1;
    check("t6_ready", rs2, 1'b1);
    @(negedge clk); d2 = 16'h5678;
    @(negedge clk); v2 = 1'b0; d2 = 16'hFFFF; #1;
    check("t6_beat", {vd2, dd2, dk2, dl2}, {1'b1, 32'h56781234, 2'b11, 1'b0});

    // Randomized traffic against the model
    begin
      int         words = 0;
      int         cycles = 0;
      int         n = 0;
      logic [7:0] pw = 8'($urandom);
      logic       pl = ($urandom % 5) == 0;
      logic       v, r;
      while (words < 10000 && cycles < 60000) begin
        v = ($urandom % 10) < 7;
        r = ($urandom % 10) < 7;
        if (words == 9999) pl = 1'b1;
        if (v) cycle(1'b1, pw, pl, r, took);
        else   cycle(1'b0, 8'($urandom), 1'($urandom), r, took);
        if (took) begin
          words++;
          pw = 8'($urandom);
          pl = ($urandom % 5) == 0;
        end
        cycles++;
      end
      check("t5_words", words, 10000);
      while (exp_q.size() > 0 && n < 100) begin
        idle(1'b1);
        n++;
      end
      check("t5_drain", exp_q.size(), 0);
      check("t5_partial", cur_q.size(), 0);
      idle(1'b1);
      check("t5_final_valid", valid_dst, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
